fwnoc_rr_arb: RTL and testbench

Packet-level round-robin arbiter that shares one ready/valid output channel, typically the `i_` side of a `fwnoc_fifo` or a router output port, among `N_PORTS` ready/valid requesters. Grant is taken on a header beat and held until the last payload beat of that packet transfers, so packets never interleave. After each packet, priority rotates to the port after the one just served.

---
 rtl/fwnoc_rr_arb.sv | 110 +++++++++++
 tb/tb_fwnoc_rr_arb.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/fwnoc_rr_arb.sv
// fwnoc_rr_arb: packet-level round-robin arbiter.
// Holds grant from header to last payload beat.
module fwnoc_rr_arb #(
  parameter int N_PORTS = 4,
  parameter int WIDTH = 32,
  localparam int GW = $clog2(N_PORTS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [N_PORTS*WIDTH-1:0] i_dat,
  input  logic [N_PORTS-1:0]       i_valid,
  output logic [N_PORTS-1:0]       i_ready,
  output logic [WIDTH-1:0]         o_dat,
  output logic                     o_valid,
  input  logic                     o_ready,
  output logic [GW-1:0]            gnt,
  output logic                     busy
);

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t      state;
  logic [GW-1:0] prio;
  logic [GW-1:0] owner;
  logic [7:0]  remain;

  logic [GW-1:0] win;
  logic [GW-1:0] sel;
  logic [GW:0]   idx;
  logic          found;
  logic          locked;
  logic          xfer;

  function automatic logic [GW-1:0] next_port(
    input logic [GW-1:0] p
  );
    if (p == GW'(N_PORTS - 1)) return '0;
    return p + GW'(1);
  endfunction

  // first valid port scanning from prio, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int i = 0; i < N_PORTS; i++) begin
      idx = {1'b0, prio} + (GW+1)'(i);
      if (idx >= (GW+1)'(N_PORTS))
        idx = idx - (GW+1)'(N_PORTS);
      if (!found && i_valid[idx[GW-1:0]]) begin
        found = 1'b1;
        win   = idx[GW-1:0];
      end
    end
  end

  // zero-cycle mux and handshake steering
  always_comb begin
    locked  = (state == LOCKED);
    sel     = locked ? owner : win;
    o_dat   = '0;
    i_ready = '0;
    for (int k = 0; k < N_PORTS; k++) begin
      if (sel == GW'(k)) begin
        o_dat      = i_dat[k*WIDTH +: WIDTH];
        i_ready[k] = o_ready & ~reset
                   & (locked | found);
      end
    end
    o_valid = ~reset
            & (locked ? i_valid[owner] : found);
    gnt     = reset ? '0 : sel;
    busy    = ~reset & locked;
    xfer    = o_valid & o_ready;
  end

  // packet lock tracking and priority rotation
  always_ff @(posedge clock) begin
    if (reset) begin
      state  <= IDLE;
      prio   <= '0;
      owner  <= '0;
      remain <= '0;
    end else if (xfer) begin
      case (state)
        IDLE: begin
          if (o_dat[7:0] == 8'd0) begin
            prio <= next_port(win);
          end else begin
            state  <= LOCKED;
            owner  <= win;
            remain <= o_dat[7:0];
          end
        end
        LOCKED: begin
          remain <= remain - 8'd1;
          if (remain == 8'd1) begin
            state <= IDLE;
            prio  <= next_port(owner);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fwnoc_rr_arb.sv
// tb_fwnoc_rr_arb: scoreboard bench for fwnoc_rr_arb.
// Requesters replay per-port beat queues.
module tb_fwnoc_rr_arb;

  localparam int N = 4;
  localparam int W = 32;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [N*W-1:0] i_dat = '0;
  logic [N-1:0]   i_valid = '0;
  logic [N-1:0]   i_ready;
  logic [W-1:0]   o_dat;
  logic           o_valid;
  logic           o_ready = 1'b0;
  logic [1:0]     gnt;
  logic           busy;

  fwnoc_rr_arb #(
    .N_PORTS(N),
    .WIDTH(W)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .i_dat  (i_dat),
    .i_valid(i_valid),
    .i_ready(i_ready),
    .o_dat  (o_dat),
    .o_valid(o_valid),
    .o_ready(o_ready),
    .gnt    (gnt),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  logic [W-1:0] pq [N][$];
  logic [33:0]  sb [$];
  logic [N-1:0] fired = '0;
  int vectors = 0;
  int errs = 0;
  int nxfer = 0;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    vectors++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h",
               tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] beat(
    input int p, input int id,
    input int i, input int len
  );
    if (i == 0)
      return {8'(p), 8'(id), 8'hA5, 8'(len)};
    return {8'(p), 8'(id), 16'(i)};
  endfunction

  task automatic send(
    input int p, input int id,
    input int len, input int nexp
  );
    logic [W-1:0] b;
    for (int i = 0; i <= len; i++) begin
      b = beat(p, id, i, len);
      pq[p].push_back(b);
      if (i < nexp) sb.push_back({2'(p), b});
    end
  endtask

  task automatic tick(input logic rdy, input logic rst);
    logic [33:0] e;
    @(posedge clock);
    #1;
    for (int k = 0; k < N; k++)
      if (fired[k]) void'(pq[k].pop_front());
    reset   = rst;
    o_ready = rdy;
    for (int k = 0; k < N; k++) begin
      i_valid[k] = (pq[k].size() > 0);
      i_dat[k*W +: W] = '0;
      if (pq[k].size() > 0) i_dat[k*W +: W] = pq[k][0];
    end
    @(negedge clock);
    fired = i_valid & i_ready;
    check("rdy_1hot",
          64'($countones(i_ready) <= 1), 64'(1));
    if (o_valid && o_ready) begin
      nxfer++;
      check("sb_avail", 64'(sb.size() > 0), 64'(1));
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("beat", 64'({gnt, o_dat}), 64'(e));
      end
    end
  endtask

  initial begin
    // reset with port 2 already requesting
    send(2, 1, 3, 4);
    tick(1'b1, 1'b1);
    check("rst_ovalid", 64'(o_valid), 0);
    check("rst_iready", 64'(i_ready), 0);
    tick(1'b1, 1'b1);
    check("rst_gnt", 64'(gnt), 0);
    check("rst_busy", 64'(busy), 0);
    check("rst_prio", 64'(dut.prio), 0);
    for (int c = 0; c < 5; c++) begin
      tick(1'b1, 1'b0);
      check("t1_busy", 64'(busy),
            64'(c >= 1 && c <= 3));
    end
    check("t1_prio", 64'(dut.prio), 3);

    // fairness with every port always valid
    tick(1'b1, 1'b1);
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < N; p++)
        send(p, 10 + r, 0, 1);
    for (int c = 0; c < 8; c++) begin
      tick(1'b1, 1'b0);
      check("fair_1hot",
            64'($countones(i_ready)), 1);
      if (c < 5) check("fair_allv", 64'(i_valid), 64'hF);
    end

    // lock holds against port 0 contention
    send(1, 20, 2, 3);
    tick(1'b1, 1'b0);
    send(0, 21, 0, 1);
    for (int c = 0; c < 2; c++) begin
      tick(1'b1, 1'b0);
      check("lock_v0", 64'(i_valid[0]), 1);
      check("lock_r0", 64'(i_ready[0]), 0);
    end
    tick(1'b1, 1'b0);
    check("lock_gnt0", 64'(gnt), 0);
    check("lock_r0up", 64'(i_ready[0]), 1);

    // backpressure mid-packet
    send(2, 30, 4, 5);
    for (int c = 0; c < 3; c++) tick(1'b1, 1'b0);
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 1'b0);
      check("bp_remain", 64'(dut.remain), 2);
      check("bp_busy", 64'(busy), 1);
      check("bp_ovalid", 64'(o_valid), 1);
    end
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);
    check("bp_idle", 64'(o_valid), 0);
    check("bp_rem0", 64'(dut.remain), 0);

    // wrap with a maximum-length packet
    check("wrap_prio3", 64'(dut.prio), 3);
    send(3, 40, 255, 256);
    nxfer = 0;
    for (int c = 0; c < 256; c++) tick(1'b1, 1'b0);
    check("wrap_beats", 64'(nxfer), 256);
    send(0, 41, 0, 1);
    send(3, 42, 0, 1);
    tick(1'b1, 1'b0);
    check("wrap_prio0", 64'(dut.prio), 0);
    check("wrap_gnt0", 64'(gnt), 0);
    tick(1'b1, 1'b0);

    // reset in the middle of a packet
    send(0, 50, 0, 1);
    send(1, 51, 5, 2);
    for (int c = 0; c < 3; c++) tick(1'b1, 1'b0);
    check("mid_busy", 64'(busy), 1);
    tick(1'b1, 1'b1);
    check("mrst_ovalid", 64'(o_valid), 0);
    check("mrst_iready", 64'(i_ready), 0);
    check("mrst_busy", 64'(busy), 0);
    pq[1].delete();
    send(0, 52, 0, 1);
    send(1, 53, 0, 1);
    tick(1'b1, 1'b0);
    check("mrst_busy2", 64'(busy), 0);
    check("mrst_prio", 64'(dut.prio), 0);
    check("mrst_gnt", 64'(gnt), 0);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b0);

    check("sb_drained", 64'(sb.size()), 0);
    check("pq_drained",
          64'(pq[0].size() + pq[1].size()
            + pq[2].size() + pq[3].size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errs);
    $finish;
  end

endmodule
